// File: rtl/rowo_dpram_sc_if.sv
// Port bundle for rowo_dpram_sc: write port, read port and registered read data.
// The write address width follows from the read/write width ratio.
interface rowo_dpram_sc_if #(
    parameter int rdw = 16,
    parameter int wdw = 16,
    parameter int raw = 9
);
    localparam int waw = (rdw >= wdw) ? raw + $clog2(rdw / wdw)
                                      : raw - $clog2(wdw / rdw);

    logic [wdw-1:0] data;
    logic [waw-1:0] wraddress;
    logic           wren;
    logic [raw-1:0] rdaddress;
    logic           rden;
    logic [rdw-1:0] q;

    modport master (
        output data,
        output wraddress,
        output wren,
        output rdaddress,
        output rden,
        input  q
    );

    modport slave (
        input  data,
        input  wraddress,
        input  wren,
        input  rdaddress,
        input  rden,
        output q
    );
endinterface

// File: rtl/rowo_dpram_sc.sv
// Simple dual-port RAM, one write-only and one read-only port on a single clock.
// Write and read widths may differ by 1/2/4/8; read data is registered, read-old-data on collision.
module rowo_dpram_sc #(
    parameter int rdw = 16,
    parameter int wdw = 16,
    parameter int raw = 9
) (
    input  logic              clk,
    input  logic              rst,
    rowo_dpram_sc_if.slave    bus
);
    localparam int ratio = (rdw >= wdw) ? rdw / wdw : wdw / rdw;
    localparam int lg    = $clog2(ratio);
    localparam int waw   = (rdw >= wdw) ? raw + lg : raw - lg;

    logic [rdw-1:0] q_r;

    generate
        if (rdw == wdw) begin : g_equal
            localparam int depth = 2 ** raw;
            logic [rdw-1:0] mem_r [depth];

            // Write port: whole-word store, blocked while reset is high
            always_ff @(posedge clk) begin
                if (!rst && bus.wren) begin
                    mem_r[bus.wraddress] <= bus.data;
                end
            end

            // Read port: registered, holds when rden is low
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r <= {rdw{1'b0}};
                end else if (bus.rden) begin
                    q_r <= mem_r[bus.rdaddress];
                end
            end
        end else if (rdw > wdw) begin : g_wide_read
            // Array is organised in read words; each write updates one slice.
            localparam int depth = 2 ** raw;
            logic [rdw-1:0] mem_r [depth];
            logic [raw-1:0] wrow_s;
            logic [lg-1:0]  wsel_s;

            assign wrow_s = bus.wraddress[waw-1:lg];
            assign wsel_s = bus.wraddress[lg-1:0];

            // Write port: little-endian slice store into the containing read word
            always_ff @(posedge clk) begin
                if (!rst && bus.wren) begin
                    mem_r[wrow_s][wsel_s*wdw +: wdw] <= bus.data;
                end
            end

            // Read port: registered full read word
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r <= {rdw{1'b0}};
                end else if (bus.rden) begin
                    q_r <= mem_r[bus.rdaddress];
                end
            end
        end else begin : g_wide_write
            // Array is organised in write words; each read extracts one slice.
            localparam int depth = 2 ** waw;
            logic [wdw-1:0] mem_r [depth];
            logic [waw-1:0] rrow_s;
            logic [lg-1:0]  rsel_s;

            assign rrow_s = bus.rdaddress[raw-1:lg];
            assign rsel_s = bus.rdaddress[lg-1:0];

            // Write port: whole write word store
            always_ff @(posedge clk) begin
                if (!rst && bus.wren) begin
                    mem_r[bus.wraddress] <= bus.data;
                end
            end

            // Read port: lowest read address maps to the least significant slice
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r <= {rdw{1'b0}};
                end else if (bus.rden) begin
                    q_r <= mem_r[rrow_s][rsel_s*rdw +: rdw];
                end
            end
        end
    endgenerate

    assign bus.q = q_r;

endmodule

// File: tb/tb_rowo_dpram_sc.sv
// Directed self-checking bench for rowo_dpram_sc in 16/16, 32/16 and 8/16 configurations.
module tb_rowo_dpram_sc;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rowo_dpram_sc_if #(.rdw(16), .wdw(16), .raw(4)) ia ();
    rowo_dpram_sc_if #(.rdw(32), .wdw(16), .raw(4)) ib ();
    rowo_dpram_sc_if #(.rdw(8),  .wdw(16), .raw(4)) ic ();

    rowo_dpram_sc #(.rdw(16), .wdw(16), .raw(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    rowo_dpram_sc #(.rdw(32), .wdw(16), .raw(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    rowo_dpram_sc #(.rdw(8),  .wdw(16), .raw(4)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        ia.data = 16'h0; ia.wraddress = 4'd0; ia.wren = 1'b0; ia.rdaddress = 4'd0; ia.rden = 1'b0;
        ib.data = 16'h0; ib.wraddress = 5'd0; ib.wren = 1'b0; ib.rdaddress = 4'd0; ib.rden = 1'b0;
        ic.data = 16'h0; ic.wraddress = 3'd0; ic.wren = 1'b0; ic.rdaddress = 4'd0; ic.rden = 1'b0;
        tick();
        tick();
        check_val("rst_a", 32'(ia.q), 32'h0);
        check_val("rst_b", ib.q, 32'h0);
        check_val("rst_c", 32'(ic.q), 32'h0);
        rst = 1'b0;

        // Basic write then read, 1-cycle latency
        ia.wren = 1'b1; ia.wraddress = 4'd3; ia.data = 16'h1234; tick();
        ia.wraddress = 4'd4; ia.data = 16'hBEEF; tick();
        ia.wren = 1'b0; ia.rden = 1'b1; ia.rdaddress = 4'd3; tick();
        check_val("rd3", 32'(ia.q), 32'h1234);
        ia.rdaddress = 4'd4; tick();
        check_val("rd4", 32'(ia.q), 32'hBEEF);

        // Read-during-write to the same address returns old data
        ia.rden = 1'b0; ia.wren = 1'b1; ia.wraddress = 4'd5; ia.data = 16'hAAAA; tick();
        ia.data = 16'h5555; ia.rden = 1'b1; ia.rdaddress = 4'd5; tick();
        check_val("rdw_old", 32'(ia.q), 32'hAAAA);
        ia.wren = 1'b0; tick();
        check_val("rdw_new", 32'(ia.q), 32'h5555);

        // Hold q with rden low while writes continue, including to the held address
        ia.rdaddress = 4'd3; tick();
        check_val("rd3_again", 32'(ia.q), 32'h1234);
        ia.rden = 1'b0; ia.wren = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ia.wraddress = (i == 0) ? 4'd3 : 4'(6 + i);
            ia.data = 16'hC000 + 16'(i);
            tick();
            check_val("hold", 32'(ia.q), 32'h1234);
        end
        ia.wren = 1'b0; ia.rden = 1'b1; ia.rdaddress = 4'd3; tick();
        check_val("rd3_ovr", 32'(ia.q), 32'hC000);
        ia.rdaddress = 4'd15; tick();
        check_val("rd15_top", 32'(ia.q), 32'hC009);

        // Simultaneous write and read to different addresses
        ia.wren = 1'b1; ia.wraddress = 4'd6; ia.data = 16'h7777; ia.rdaddress = 4'd4; tick();
        check_val("diff_rd", 32'(ia.q), 32'hBEEF);
        ia.wren = 1'b0; ia.rdaddress = 4'd6; tick();
        check_val("diff_wr", 32'(ia.q), 32'h7777);

        // Wide read: two 16-bit writes pack little-endian into one 32-bit word
        ib.wren = 1'b1; ib.wraddress = 5'd6; ib.data = 16'h1111; tick();
        ib.wraddress = 5'd7; ib.data = 16'h2222; tick();
        ib.wraddress = 5'd0; ib.data = 16'hCAFE; tick();
        ib.wraddress = 5'd1; ib.data = 16'hF00D; tick();
        ib.wren = 1'b0; ib.rden = 1'b1; ib.rdaddress = 4'd3; tick();
        check_val("wide_rd3", ib.q, 32'h22221111);
        ib.rdaddress = 4'd0; tick();
        check_val("wide_rd0", ib.q, 32'hF00DCAFE);

        // Narrow read: the lowest read address gets the low byte
        ic.wren = 1'b1; ic.wraddress = 3'd2; ic.data = 16'hA55A; tick();
        ic.wraddress = 3'd7; ic.data = 16'h1357; tick();
        ic.wren = 1'b0; ic.rden = 1'b1; ic.rdaddress = 4'd4; tick();
        check_val("narrow_rd4", 32'(ic.q), 32'h5A);
        ic.rdaddress = 4'd5; tick();
        check_val("narrow_rd5", 32'(ic.q), 32'hA5);
        ic.rdaddress = 4'd15; tick();
        check_val("narrow_rd15", 32'(ic.q), 32'h13);
        ic.rdaddress = 4'd14; tick();
        check_val("narrow_rd14", 32'(ic.q), 32'h57);

        // Asynchronous reset mid-stream; writes during reset must be dropped
        ia.rdaddress = 4'd4; tick();
        check_val("pre_rst", 32'(ia.q), 32'hBEEF);
        ib.rdaddress = 4'd3;
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_async_a", 32'(ia.q), 32'h0);
        check_val("rst_async_b", ib.q, 32'h0);
        check_val("rst_async_c", 32'(ic.q), 32'h0);
        ia.wren = 1'b1; ia.wraddress = 4'd4; ia.data = 16'hDEAD;
        tick();
        check_val("rst_hold1", 32'(ia.q), 32'h0);
        tick();
        check_val("rst_hold2", 32'(ia.q), 32'h0);
        rst = 1'b0;
        ia.wren = 1'b0;
        tick();
        check_val("post_rst_a4", 32'(ia.q), 32'hBEEF);
        check_val("post_rst_b3", ib.q, 32'h22221111);
        check_val("post_rst_c14", 32'(ic.q), 32'h57);
        ia.rdaddress = 4'd3; tick();
        check_val("post_rst_a3", 32'(ia.q), 32'hC000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
